riscv_muxn_pipe: RTL and testbench
==================================

Name: riscv_muxn_pipe

Overview:
Parametrised N-input, registered select stage for the RISC-V datapath. It is the pipelined successor of the fixed 5-input combinational mux. It selects one of NUM_IN packed operands, flags out-of-range selects, and registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the stage can absorb a downstream stall without dropping data. Used on operand-forwarding and writeback-select paths where timing requires a register boundary.

Parameters:
WIDTH, 64, data width of each input and of the output
NUM_IN, 5, number of selectable inputs, legal range 2..(2**SEL_W)
SEL_W, 3, select width; encodings >= NUM_IN are out of range

Ports:
i_riscv_clk  input  1  clock, rising edge
i_riscv_rst_n  input  1  asynchronous reset, active low
i_riscv_muxn_flush  input  1  synchronous flush of all buffered beats
i_riscv_muxn_valid  input  1  upstream beat valid
o_riscv_muxn_ready  output  1  stage can accept a beat this cycle
i_riscv_muxn_sel  input  SEL_W  input select, sampled with the beat
i_riscv_muxn_in  input  NUM_IN*WIDTH  packed inputs; input k = bits [k*WIDTH +: WIDTH]
o_riscv_muxn_valid  output  1  output beat valid
i_riscv_muxn_ready  input  1  downstream accepts the output beat
o_riscv_muxn_out  output  WIDTH  selected data of the head beat
o_riscv_muxn_err  output  1  head beat had an out-of-range select

Behaviour:
- Reset is asynchronous and active low. While i_riscv_rst_n=0: o_valid=0, o_out=0, o_err=0, skid entry empty with data 0. o_ready=1, because it is derived as !skid_valid.
- Selection (combinational, pre-register): sel<NUM_IN gives data=in[sel], err=0. sel>=NUM_IN gives data=0, err=1.
- Accept: accept = i_valid & o_ready. Outputs are driven from registers only; no combinational path from i_* to o_out, o_err or o_valid.
- Output consumed: drain = o_valid & i_ready.
- Storage: main register (head, drives outputs) plus one skid register. o_ready = !skid_valid, registered.
- Per-cycle update, flush=0:
  - main empty or drain, skid empty: accepted beat loads main. If nothing is accepted, main_valid clears.
  - main empty or drain, skid full: skid moves to main and skid clears. No accept is possible this cycle because o_ready=0.
  - main full, no drain, accept: beat loads skid, so o_ready=0 next cycle.
  - main full, no drain, no accept: hold. o_out and o_err must stay stable while o_valid=1 and i_ready=0.
- Latency: 1 cycle from accept to o_valid when the stage is empty. Sustained throughput is 1 beat per cycle when i_ready=1.
- Ordering: strict FIFO. Beats are never dropped or duplicated. The err bit travels with its beat.
- Flush, synchronous, has the highest priority:
  - Next edge: main_valid=0, skid_valid=0, o_out=0, o_err=0.
  - A beat presented in the flush cycle is discarded. A drain in the same cycle still counts as delivered.
  - o_ready=1 the cycle after flush.
- Reset mid-operation immediately clears both entries, independent of the clock.
- Parameter check: NUM_IN > 2**SEL_W or NUM_IN < 2 is a synthesis-time error (generate-time check).

Test Plan:
- Reset then single beat: release reset, sel=2, in2=64'hDEAD_BEEF_0000_0002, valid one cycle, i_ready=1 -> o_valid=1 the next cycle with o_out=64'hDEAD_BEEF_0000_0002, err=0. o_valid=0 the cycle after.
- Out-of-range select: NUM_IN=5, sel=3'b110 with all inputs nonzero -> o_out=0, o_err=1 one cycle later. sel=3'b111 gives the same result.
- Back-pressure: stream sel=0,1,2,3 back-to-back with i_ready=0 from cycle 1 -> o_out holds the in0 value. Beat 2 fills skid, o_ready=0, beat 3 is held upstream. Raise i_ready -> outputs in0,in1,in2,in3 in order, with no loss or duplicate.
- Full throughput: 16 consecutive beats, sel cycling 0..4, i_ready=1 -> 16 output beats on consecutive cycles, o_ready constantly 1.
- Flush with both entries full, valid input in the same cycle -> next cycle o_valid=0, o_out=0, o_ready=1. The flushed-cycle beat never appears at the output.
- Asynchronous reset asserted mid-clock with skid full -> o_valid=0 and o_out=0 immediately, before the next edge. o_ready=1 while in reset.

Source files
------------

// File: rtl/riscv_muxn_pipe.sv
// N-input registered select stage with a valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects produce zero data and an error bit that travels with the beat.
module riscv_muxn_pipe #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    i_riscv_clk,
    input  logic                    i_riscv_rst_n,
    input  logic                    i_riscv_muxn_flush,
    input  logic                    i_riscv_muxn_valid,
    output logic                    o_riscv_muxn_ready,
    input  logic [SEL_W-1:0]        i_riscv_muxn_sel,
    input  logic [NUM_IN*WIDTH-1:0] i_riscv_muxn_in,
    output logic                    o_riscv_muxn_valid,
    input  logic                    i_riscv_muxn_ready,
    output logic [WIDTH-1:0]        o_riscv_muxn_out,
    output logic                    o_riscv_muxn_err
);

    generate
        if (NUM_IN < 2 || NUM_IN > (2 ** SEL_W)) begin : g_bad_num_in
            $error("riscv_muxn_pipe: NUM_IN must lie in 2..2**SEL_W");
        end
    endgenerate

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             main_err_q,   main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             skid_err_q,   skid_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             drain;

    // Select before the register; an encoding with no matching input falls through as an error.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_riscv_muxn_sel == SEL_W'(k)) begin
                sel_data = i_riscv_muxn_in[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign o_riscv_muxn_ready = !skid_valid_q;
    assign o_riscv_muxn_valid = main_valid_q;
    assign o_riscv_muxn_out   = main_data_q;
    assign o_riscv_muxn_err   = main_err_q;

    assign accept = i_riscv_muxn_valid & !skid_valid_q;
    assign drain  = main_valid_q & i_riscv_muxn_ready;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path can infer a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;

        if (i_riscv_muxn_flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_err_d   = 1'b0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_err_d   = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                // Skid beat is older than anything upstream; ready was low so nothing is accepted.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
                skid_err_d   = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = sel_data;
                main_err_d   = sel_err;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_err_d   = sel_err;
        end
    end

    // NOTE: data registers are reset too, since the outputs must read zero while in reset.
    always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
        if (!i_riscv_rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_muxn_pipe.sv
// Self-checking bench for riscv_muxn_pipe: table-driven vectors plus flush and async-reset sequences.
module tb_riscv_muxn_pipe;

    localparam int WIDTH  = 64;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel = '0;
    logic [NUM_IN*WIDTH-1:0] din;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [WIDTH-1:0]        dout;
    logic                    derr;

    int total = 0;
    int bad   = 0;

    riscv_muxn_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .i_riscv_clk        (clk),
        .i_riscv_rst_n      (rst_n),
        .i_riscv_muxn_flush (flush),
        .i_riscv_muxn_valid (in_valid),
        .o_riscv_muxn_ready (in_ready),
        .i_riscv_muxn_sel   (sel),
        .i_riscv_muxn_in    (din),
        .o_riscv_muxn_valid (out_valid),
        .i_riscv_muxn_ready (out_ready),
        .o_riscv_muxn_out   (dout),
        .o_riscv_muxn_err   (derr)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] in_val(input int k);
        return 64'hDEAD_BEEF_0000_0000 + 64'(k);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic dr, input logic fl);
        in_valid  = v;
        sel       = s;
        out_ready = dr;
        flush     = fl;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic             dready;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_out;
        logic             exp_err;
        logic             exp_ready;
    } vec_t;

    vec_t vecs[13];

    initial begin
        for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = in_val(k);

        // single beat, out-of-range selects, then back-pressure with skid fill and release
        vecs[0]  = '{1'b1, 3'd2, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0002, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 64'h0,                  1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'd6, 1'b1, 1'b1, 64'h0,                  1'b1, 1'b1};
        vecs[3]  = '{1'b1, 3'd7, 1'b1, 1'b1, 64'h0,                  1'b1, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0004, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 1'b1, 1'b0, 64'h0,                  1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'd1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 3'd2, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 3'd2, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0002, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd3, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0003, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 1'b1, 1'b0, 64'h0,                  1'b0, 1'b1};

        // reset values while held in reset
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.out",   dout,           64'd0);
        check("rst.err",   64'(derr),      64'd0);
        check("rst.ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].dready, 1'b0);
            tick();
            check($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d.ready", i), 64'(in_ready),  64'(vecs[i].exp_ready));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d.out", i), dout,      vecs[i].exp_out);
                check($sformatf("vec%0d.err", i), 64'(derr), 64'(vecs[i].exp_err));
            end
        end

        // full throughput: 16 beats back-to-back, sel cycling 0..4
        for (int b = 0; b < 16; b++) begin
            drive(1'b1, SEL_W'(b % NUM_IN), 1'b1, 1'b0);
            tick();
            check($sformatf("tput%0d.valid", b), 64'(out_valid), 64'd1);
            check($sformatf("tput%0d.out", b),   dout,           in_val(b % NUM_IN));
            check($sformatf("tput%0d.ready", b), 64'(in_ready),  64'd1);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        check("tput.tail.valid", 64'(out_valid), 64'd0);

        // flush with both entries full and a new beat presented in the flush cycle
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        check("flush.pre.ready", 64'(in_ready), 64'd0);
        drive(1'b1, 3'd3, 1'b0, 1'b1);
        tick();
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.out",   dout,           64'd0);
        check("flush.err",   64'(derr),      64'd0);
        check("flush.ready", 64'(in_ready),  64'd1);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("flush.after%0d.valid", c), 64'(out_valid), 64'd0);
        end

        // async reset mid-cycle with skid full (skid beat carries an error)
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("arst.pre.valid", 64'(out_valid), 64'd1);
        check("arst.pre.ready", 64'(in_ready),  64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.out",   dout,           64'd0);
        check("arst.err",   64'(derr),      64'd0);
        check("arst.ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        check("arst.after.valid", 64'(out_valid), 64'd0);
        check("arst.after.ready", 64'(in_ready),  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
